twomux_rr_arb: RTL and testbench

Two-source round-robin arbiter that sits directly upstream of the 2:1 output mux. It accepts words from sources A and B over valid/ready handshakes and selects one source per cycle with bounded-burst fairness. It registers the winning word and drives `sel` to the mux stage. `sel` identifies the source of the held word: 0 = A, 1 = B.

---
 rtl/twomux_rr_arb.sv | 132 +++++++++++++
 tb/tb_twomux_rr_arb.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/twomux_rr_arb.sv
// Two-source round-robin arbiter feeding a 2:1 output mux.
// Holds the winning word in a single output register and reports its source on sel.
module twomux_rr_arb #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned BURST = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             sel,
  input  logic             out_ready
);

  localparam int unsigned RUN_W = 4;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(BURST);

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  // Output register and priority state
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  src_e             r_sel;
  src_e             r_last;
  logic [RUN_W-1:0] r_run;

  logic             w_out_valid_nxt;
  logic [WIDTH-1:0] w_out_data_nxt;
  src_e             w_sel_nxt;
  src_e             w_last_nxt;
  logic [RUN_W-1:0] w_run_nxt;

  logic             w_load;
  logic             w_gnt_vld;
  src_e             w_gnt;
  src_e             w_other;
  logic             w_xfer;
  logic [WIDTH-1:0] w_gnt_data;
  logic [RUN_W:0]   w_run_inc;

  assign w_load  = !r_out_valid || out_ready;
  assign w_other = (r_last == SRC_A) ? SRC_B : SRC_A;

  // Grant selection; under contention the incumbent keeps the grant until its run saturates
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = SRC_A;
    unique case ({a_valid, b_valid})
      2'b10: begin
        w_gnt_vld = 1'b1;
        w_gnt     = SRC_A;
      end
      2'b01: begin
        w_gnt_vld = 1'b1;
        w_gnt     = SRC_B;
      end
      2'b11: begin
        w_gnt_vld = 1'b1;
        w_gnt     = (r_run < RUN_MAX) ? r_last : w_other;
      end
      default: begin
        w_gnt_vld = 1'b0;
        w_gnt     = SRC_A;
      end
    endcase
  end

  // Readys are gated by rstn so no handshake can complete while reset is held
  assign a_ready = rstn && w_load && w_gnt_vld && (w_gnt == SRC_A);
  assign b_ready = rstn && w_load && w_gnt_vld && (w_gnt == SRC_B);

  assign w_xfer     = w_load && w_gnt_vld;
  assign w_gnt_data = (w_gnt == SRC_B) ? b_data : a_data;
  assign w_run_inc  = {1'b0, r_run} + (RUN_W+1)'(1);

  // Next-state for output register and priority state
  always_comb begin
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_sel_nxt       = r_sel;
    w_last_nxt      = r_last;
    w_run_nxt       = r_run;
    if (w_xfer) begin
      w_out_valid_nxt = 1'b1;
      w_out_data_nxt  = w_gnt_data;
      w_sel_nxt       = w_gnt;
      if (w_gnt == r_last) begin
        if (w_run_inc > {1'b0, RUN_MAX}) begin
          w_run_nxt = RUN_MAX;
        end else begin
          w_run_nxt = w_run_inc[RUN_W-1:0];
        end
      end else begin
        w_last_nxt = w_gnt;
        w_run_nxt  = RUN_W'(1);
      end
    end else if (out_ready) begin
      w_out_valid_nxt = 1'b0;
    end
  end

  // State registers; reset leaves B as last with a saturated run so A wins first contention
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_sel       <= SRC_A;
      r_last      <= SRC_B;
      r_run       <= RUN_MAX;
    end else begin
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_sel       <= w_sel_nxt;
      r_last      <= w_last_nxt;
      r_run       <= w_run_nxt;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign sel       = r_sel;

endmodule

// File: tb/tb_twomux_rr_arb.sv
// Bench for twomux_rr_arb: two instances (BURST=2 and BURST=1) driven in lockstep,
// checked against a table, hand sequences and a streak-counting reference model.
module tb_twomux_rr_arb;

  logic       clk = 1'b0;
  logic       rstn;
  logic       a_valid, b_valid, out_ready;
  logic [3:0] a_data, b_data;
  logic [1:0] ar, br, ov, sl;
  logic [3:0] od [2];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  twomux_rr_arb #(.WIDTH(4), .BURST(2)) u_dut0 (
    .clk(clk), .rstn(rstn),
    .a_valid(a_valid), .a_data(a_data), .a_ready(ar[0]),
    .b_valid(b_valid), .b_data(b_data), .b_ready(br[0]),
    .out_valid(ov[0]), .out_data(od[0]), .sel(sl[0]), .out_ready(out_ready)
  );

  twomux_rr_arb #(.WIDTH(4), .BURST(1)) u_dut1 (
    .clk(clk), .rstn(rstn),
    .a_valid(a_valid), .a_data(a_data), .a_ready(ar[1]),
    .b_valid(b_valid), .b_data(b_data), .b_ready(br[1]),
    .out_valid(ov[1]), .out_data(od[1]), .sel(sl[1]), .out_ready(out_ready)
  );

  // Reference model: streak is an unbounded count of consecutive grants to 'last'
  typedef struct {
    int         last;
    int         streak;
    bit         ov;
    logic [3:0] od;
    bit         sel;
  } mdl_t;

  mdl_t m [2];
  int   burst_of [2] = '{2, 1};

  typedef struct {
    bit         av;
    logic [3:0] ad;
    bit         bv;
    logic [3:0] bd;
    bit         ordy;
    bit         e_ar;
    bit         e_br;
    bit         e_ov;
    logic [3:0] e_od;
    bit         e_sel;
  } vec_t;

  vec_t tbl [13];

  function automatic mdl_t model_reset(int burst);
    mdl_t s;
    s.last = 1; s.streak = burst; s.ov = 1'b0; s.od = 4'h0; s.sel = 1'b0;
    return s;
  endfunction

  function automatic int model_grant(mdl_t s, int burst, bit av, bit bv);
    if (av && !bv) return 0;
    if (bv && !av) return 1;
    if (!av && !bv) return -1;
    return (s.streak < burst) ? s.last : 1 - s.last;
  endfunction

  function automatic mdl_t model_step(mdl_t s, int burst, bit av, logic [3:0] ad,
                                      bit bv, logic [3:0] bd, bit ordy);
    mdl_t n;
    int   g;
    bit   ld;
    n  = s;
    g  = model_grant(s, burst, av, bv);
    ld = !s.ov || ordy;
    if (ld && g >= 0) begin
      n.ov  = 1'b1;
      n.od  = (g == 1) ? bd : ad;
      n.sel = (g == 1);
      if (g == s.last) n.streak = s.streak + 1;
      else begin
        n.last   = g;
        n.streak = 1;
      end
    end else if (ordy) begin
      n.ov = 1'b0;
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive after negedge, check readys, take posedge, check outputs at next negedge
  task automatic cycle(input bit av, input logic [3:0] ad, input bit bv, input logic [3:0] bd,
                       input bit ordy, output bit obs_ar, output bit obs_br);
    int g;
    bit ld;
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = ordy;
    #1;
    obs_ar = ar[0];
    obs_br = br[0];
    for (int i = 0; i < 2; i++) begin
      g  = model_grant(m[i], burst_of[i], av, bv);
      ld = !m[i].ov || ordy;
      chk($sformatf("a_ready[%0d]", i), 32'(ar[i]), 32'(ld && g == 0));
      chk($sformatf("b_ready[%0d]", i), 32'(br[i]), 32'(ld && g == 1));
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) m[i] = model_step(m[i], burst_of[i], av, ad, bv, bd, ordy);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("out_valid[%0d]", i), 32'(ov[i]), 32'(m[i].ov));
      chk($sformatf("out_data[%0d]", i), 32'(od[i]), 32'(m[i].od));
      chk($sformatf("sel[%0d]", i), 32'(sl[i]), 32'(m[i].sel));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    a_valid = 1'b1; b_valid = 1'b1; a_data = 4'ha; b_data = 4'hb; out_ready = 1'b1;
    rstn = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_out_valid[%0d]", i), 32'(ov[i]), 32'd0);
      chk($sformatf("rst_out_data[%0d]", i), 32'(od[i]), 32'd0);
      chk($sformatf("rst_sel[%0d]", i), 32'(sl[i]), 32'd0);
      chk($sformatf("rst_a_ready[%0d]", i), 32'(ar[i]), 32'd0);
      chk($sformatf("rst_b_ready[%0d]", i), 32'(br[i]), 32'd0);
      m[i] = model_reset(burst_of[i]);
    end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit         xa, xb;
    bit         e_sel1 [8];
    logic [3:0] e_od1 [8];

    // av ad bv bd ordy | e_ar e_br | e_ov e_od e_sel  (BURST=2 instance)
    tbl[0]  = '{1'b1, 4'ha, 1'b1, 4'hb, 1'b1, 1'b1, 1'b0, 1'b1, 4'ha, 1'b0};
    tbl[1]  = '{1'b1, 4'ha, 1'b1, 4'hb, 1'b1, 1'b1, 1'b0, 1'b1, 4'ha, 1'b0};
    tbl[2]  = '{1'b1, 4'ha, 1'b1, 4'hb, 1'b1, 1'b0, 1'b1, 1'b1, 4'hb, 1'b1};
    tbl[3]  = '{1'b1, 4'ha, 1'b1, 4'hb, 1'b1, 1'b0, 1'b1, 1'b1, 4'hb, 1'b1};
    tbl[4]  = '{1'b1, 4'ha, 1'b1, 4'hb, 1'b1, 1'b1, 1'b0, 1'b1, 4'ha, 1'b0};
    tbl[5]  = '{1'b1, 4'ha, 1'b1, 4'hb, 1'b0, 1'b0, 1'b0, 1'b1, 4'ha, 1'b0};
    tbl[6]  = '{1'b1, 4'ha, 1'b1, 4'hb, 1'b0, 1'b0, 1'b0, 1'b1, 4'ha, 1'b0};
    tbl[7]  = '{1'b1, 4'ha, 1'b1, 4'hb, 1'b1, 1'b1, 1'b0, 1'b1, 4'ha, 1'b0};
    tbl[8]  = '{1'b0, 4'h3, 1'b0, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0, 4'ha, 1'b0};
    tbl[9]  = '{1'b0, 4'h3, 1'b0, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0, 4'ha, 1'b0};
    tbl[10] = '{1'b0, 4'h3, 1'b1, 4'h7, 1'b1, 1'b0, 1'b1, 1'b1, 4'h7, 1'b1};
    tbl[11] = '{1'b1, 4'h5, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1, 4'h7, 1'b1};
    tbl[12] = '{1'b1, 4'h5, 1'b0, 4'h7, 1'b1, 1'b1, 1'b0, 1'b1, 4'h5, 1'b0};

    rstn = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0; a_data = 4'h0; b_data = 4'h0; out_ready = 1'b0;

    do_reset();
    for (int k = 0; k < 13; k++) begin
      cycle(tbl[k].av, tbl[k].ad, tbl[k].bv, tbl[k].bd, tbl[k].ordy, xa, xb);
      chk($sformatf("tbl%0d_a_ready", k), 32'(xa), 32'(tbl[k].e_ar));
      chk($sformatf("tbl%0d_b_ready", k), 32'(xb), 32'(tbl[k].e_br));
      chk($sformatf("tbl%0d_out_valid", k), 32'(ov[0]), 32'(tbl[k].e_ov));
      chk($sformatf("tbl%0d_out_data", k), 32'(od[0]), 32'(tbl[k].e_od));
      chk($sformatf("tbl%0d_sel", k), 32'(sl[0]), 32'(tbl[k].e_sel));
    end

    // A alone saturates its run, so B wins the first contended cycle and gets two grants
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 4'(k + 1), 1'b0, 4'h0, 1'b1, xa, xb);
      chk("solo_a_sel", 32'(sl[0]), 32'd0);
      chk("solo_a_data", 32'(od[0]), 32'(k + 1));
    end
    cycle(1'b1, 4'h6, 1'b1, 4'hc, 1'b1, xa, xb);
    chk("contend1_sel", 32'(sl[0]), 32'd1);
    cycle(1'b1, 4'h6, 1'b1, 4'hd, 1'b1, xa, xb);
    chk("contend2_sel", 32'(sl[0]), 32'd1);
    cycle(1'b1, 4'h6, 1'b1, 4'he, 1'b1, xa, xb);
    chk("contend3_sel", 32'(sl[0]), 32'd0);
    chk("contend3_data", 32'(od[0]), 32'h6);

    // BURST=1 alternates strictly; each word is held across the stalled cycle
    do_reset();
    e_sel1 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    e_od1  = '{4'ha, 4'ha, 4'hb, 4'hb, 4'ha, 4'ha, 4'hb, 4'hb};
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 4'ha, 1'b1, 4'hb, (k % 2) == 0, xa, xb);
      chk($sformatf("alt%0d_sel", k), 32'(sl[1]), 32'(e_sel1[k]));
      chk($sformatf("alt%0d_data", k), 32'(od[1]), 32'(e_od1[k]));
    end

    // Reset while a B word is held, then the next contended grant goes to A
    do_reset();
    cycle(1'b0, 4'h0, 1'b1, 4'h9, 1'b1, xa, xb);
    chk("pre_rst_sel", 32'(sl[0]), 32'd1);
    a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b0;
    rstn = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(ov[0]), 32'd0);
    chk("mid_rst_sel", 32'(sl[0]), 32'd0);
    chk("mid_rst_a_ready", 32'(ar[0]), 32'd0);
    chk("mid_rst_b_ready", 32'(br[0]), 32'd0);
    for (int i = 0; i < 2; i++) m[i] = model_reset(burst_of[i]);
    @(negedge clk);
    rstn = 1'b1;
    cycle(1'b1, 4'ha, 1'b1, 4'hb, 1'b1, xa, xb);
    chk("post_rst_a_ready", 32'(xa), 32'd1);
    chk("post_rst_sel", 32'(sl[0]), 32'd0);

    // Randomized traffic against the model
    for (int k = 0; k < 2000; k++) begin
      cycle(($urandom_range(0, 3) != 0), 4'($urandom), ($urandom_range(0, 3) != 0),
            4'($urandom), ($urandom_range(0, 2) != 0), xa, xb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
